// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial double-dabble binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DEF_BIN_W  = 20;
    localparam int DEF_DIGITS = 6;
    localparam int DEF_CNT_W  = 5;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int          BCD_W   = 4 * DEF_DIGITS;
    localparam int unsigned MAX_DEC = pow10(DEF_DIGITS) - 1;
    localparam logic [3:0]  ADD3_TH = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: digits of 5 or more get +3 ahead of the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= ADD3_TH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_serial_converter.sv
// Bit-serial double-dabble converter: one shift per clock, ready/valid on both sides,
// saturating overflow and a leading-zero blanking mask for the display driver.
module bcd_serial_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [BIN_W-1:0]      bin_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic                  overflow_o,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int          ACC_W = 4 * DIGITS;
    localparam logic [31:0] MAX_V = 32'(pow10(DIGITS) - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_sr;
    logic [ACC_W-1:0]   acc, acc_adj, acc_shf;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_q;
    logic               last_shift;

    // Digit i stays lit if it or any more significant digit is nonzero; units always lit.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [ACC_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen | (|v[4*i +: 4]);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit (acc[4*g +: 4]),
            .adj   (acc_adj[4*g +: 4])
        );
    end

    assign acc_shf    = {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};
    assign last_shift = (state == SHIFT) && (cnt == LAST);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_sr        <= '0;
            acc           <= '0;
            cnt           <= '0;
            ovf_q         <= 1'b0;
            bcd_o         <= '0;
            digit_valid_o <= DIGITS'(1);
            overflow_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    bin_sr <= bin_i;
                    acc    <= '0;
                    cnt    <= '0;
                    ovf_q  <= (32'(bin_i) > MAX_V);
                end
                SHIFT: begin
                    acc    <= acc_shf;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt + CNT_W'(1);
                    // The top accumulator bit can be lost only when the input overflowed, so saturate then.
                    if (cnt == LAST) begin
                        bcd_o         <= ovf_q ? {DIGITS{4'h9}} : acc_shf;
                        digit_valid_o <= ovf_q ? {DIGITS{1'b1}} : blank_mask(acc_shf);
                        overflow_o    <= ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
